rw_read_stage: RTL
==================

RW_READ_STAGE -- requirements
Module: rw_read_stage

Interface
REQ-001 SHALL have parameter N_THREADS, default 16, the thread-ID space; TID_W = clog2(N_THREADS).
REQ-002 SHALL have parameter CQ_SLOTS, default 64, the commit-queue slots; SLOT_W = clog2(CQ_SLOTS).
REQ-003 SHALL have parameter OBJ_W, default 32, legal values 32/64/128/256/512, the object width.
REQ-004 SHALL have parameter TASK_W, default 96, the opaque task-descriptor width.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 8, the hard cap on in-flight reads.
REQ-006 Ports SHALL be, as clk/rstn first: clk in 1 clock; rstn in 1 reset, synchronous, active-low.
REQ-007 in_valid in 1; in_ready out 1; in_task in TASK_W; in_locale in 32; in_no_read in 1; in_restore in 1; in_slot in SLOT_W; in_thread in TID_W.
REQ-008 arvalid out 1; arready in 1; araddr out 32; arid out TID_W; rvalid in 1; rready out 1; rid in TID_W; rdata in 512.
REQ-009 out_valid out 1; out_ready in 1; out_task out TASK_W; out_locale out 32; out_slot out SLOT_W; out_thread out TID_W; out_object out OBJ_W.
REQ-010 out_fifo_occ in 8, downstream occupancy; gvt_valid in 1; gvt_slot in SLOT_W.
REQ-011 cfg_wvalid in 1; cfg_waddr in 8; cfg_wdata in 32; cfg_arvalid in 1; cfg_araddr in 8; cfg_rvalid out 1; cfg_rdata out 32.

Function
REQ-012 can_deq SHALL equal (deq_remaining != 0) AND (outstanding < max_out) AND ((out_fifo_occ < thresh) OR (gvt_valid AND gvt_slot == in_slot)).
REQ-013 A read task, with in_no_read=0 and in_restore=0, SHALL assert arvalid when in_valid AND can_deq; in_ready SHALL equal arvalid AND arready.
REQ-014 A bypass task, with in_no_read=1 or in_restore=1, SHALL assert in_ready only when can_deq AND the bypass register is empty or is being drained this cycle; it SHALL never assert arvalid.
REQ-015 araddr SHALL equal base + in_locale * (OBJ_W/8), modulo 2^32; arid SHALL equal in_thread.
REQ-016 On accept, the per-thread context table SHALL store {in_task, in_locale, in_slot} at index in_thread.
REQ-017 On accept of a read task, outstanding SHALL increment; on rvalid AND rready, outstanding SHALL decrement; simultaneous events SHALL leave it unchanged.
REQ-018 The bypass register SHALL load on bypass accept and SHALL present its entry one cycle later.
REQ-019 Output priority SHALL be: bypass register first, then rvalid; rready SHALL equal rvalid AND out_ready AND bypass register empty.
REQ-020 Read response: the context fields SHALL come from the table at rid, out_thread SHALL equal rid, and out_object SHALL equal rdata[locale[k-1:0]*OBJ_W +: OBJ_W], where k = log2(512/OBJ_W); for OBJ_W=512, out_object SHALL equal rdata.
REQ-021 Restore: out_object SHALL be the undo-log word at in_slot, read on the accept cycle; no_read: out_object SHALL be 0.
REQ-022 The undo log, CQ_SLOTS x OBJ_W, SHALL write out_object at out_slot on every out_valid AND out_ready; a restore reading the same slot in that cycle SHALL get the new data (write-first).
REQ-023 deq_remaining SHALL decrement on each accept and saturate at 0; a cfg write in the same cycle SHALL win.
REQ-024 Writes SHALL take effect next cycle: 0x00 base = {wdata[29:0],2'b00}; 0x04 thresh = wdata[7:0]; 0x08 deq_remaining; 0x0C max_out = min(wdata, MAX_OUTSTANDING).
REQ-025 cfg_rvalid SHALL pulse one cycle after cfg_arvalid; 0x04 SHALL return out_fifo_occ; 0x0C SHALL return outstanding; unmapped addresses SHALL return 0.

Reset
REQ-026 On rstn=0, at the next clk edge: base=0, thresh=8'hFF, deq_remaining=32'hFFFFFFFF, max_out=MAX_OUTSTANDING, outstanding=0, bypass register empty, cfg_rvalid=0.
REQ-027 During reset, in_ready, arvalid, rready and out_valid SHALL be 0; the table and undo log SHALL not be cleared; responses in flight across reset SHALL be dropped by rready=0 only while rstn=0.

Configuration
REQ-028 With RW_READ_STATS_EN defined, 32-bit saturating counters SHALL exist for reads issued (0x10), bypass tasks (0x14) and cycles stalled by threshold (0x18); they SHALL reset to 0 and be readable.
REQ-029 Without RW_READ_STATS_EN, no counters SHALL exist and 0x10-0x18 SHALL read 0.

Verification
REQ-030 OBJ_W=64, base=0x1000, locale=5, read task -> araddr=0x1028; rdata lane 5 returned -> out_object equals rdata[383:320].
REQ-031 max_out=2, three read tasks with arready=1 -> third held, in_ready=0, until one rvalid handshake, then accepted next cycle.
REQ-032 out_fifo_occ=thresh=4 -> in_ready=0; gvt_valid=1 and gvt_slot=in_slot -> accepted.
REQ-033 Output slot 3 writes 0xCAFE; restore task for slot 3 accepted the same cycle -> one cycle later out_object=0xCAFE.
REQ-034 Bypass register full, rvalid=1, out_ready=1 -> bypass emitted first and rready=0; rid response emitted next cycle.
REQ-035 deq_remaining=1 -> one accept, then in_ready=0; cfg write 0x08=3 coincident with an accept -> value becomes 3.

Source files
------------

// File: rtl/rw_read_stage_if.sv
// rw_read_stage_if: the task-in, AXI-read, task-out and config buses of
// rw_read_stage, grouped as one bundle.
//   slave  : used by rw_read_stage (consumes tasks, issues AR, emits tasks)
//   master : used by the surrounding logic / testbench
// Parameters must match those given to rw_read_stage.
interface rw_read_stage_if #(
  parameter int N_THREADS = 16,
  parameter int CQ_SLOTS  = 64,
  parameter int OBJ_W     = 32,
  parameter int TASK_W    = 96
);
  localparam int TID_W  = $clog2(N_THREADS);
  localparam int SLOT_W = $clog2(CQ_SLOTS);

  // task input
  logic              in_valid;
  logic              in_ready;
  logic [TASK_W-1:0] in_task;
  logic [31:0]       in_locale;
  logic              in_no_read;
  logic              in_restore;
  logic [SLOT_W-1:0] in_slot;
  logic [TID_W-1:0]  in_thread;
  // memory read
  logic              arvalid;
  logic              arready;
  logic [31:0]       araddr;
  logic [TID_W-1:0]  arid;
  logic              rvalid;
  logic              rready;
  logic [TID_W-1:0]  rid;
  logic [511:0]      rdata;
  // task output
  logic              out_valid;
  logic              out_ready;
  logic [TASK_W-1:0] out_task;
  logic [31:0]       out_locale;
  logic [SLOT_W-1:0] out_slot;
  logic [TID_W-1:0]  out_thread;
  logic [OBJ_W-1:0]  out_object;
  // flow-control side inputs
  logic [7:0]        out_fifo_occ;
  logic              gvt_valid;
  logic [SLOT_W-1:0] gvt_slot;
  // config port
  logic              cfg_wvalid;
  logic [7:0]        cfg_waddr;
  logic [31:0]       cfg_wdata;
  logic              cfg_arvalid;
  logic [7:0]        cfg_araddr;
  logic              cfg_rvalid;
  logic [31:0]       cfg_rdata;

  modport slave (
    input  in_valid, in_task, in_locale, in_no_read, in_restore, in_slot, in_thread,
    output in_ready,
    output arvalid, araddr, arid, rready,
    input  arready, rvalid, rid, rdata,
    output out_valid, out_task, out_locale, out_slot, out_thread, out_object,
    input  out_ready, out_fifo_occ, gvt_valid, gvt_slot,
    input  cfg_wvalid, cfg_waddr, cfg_wdata, cfg_arvalid, cfg_araddr,
    output cfg_rvalid, cfg_rdata
  );

  modport master (
    output in_valid, in_task, in_locale, in_no_read, in_restore, in_slot, in_thread,
    input  in_ready,
    input  arvalid, araddr, arid, rready,
    output arready, rvalid, rid, rdata,
    input  out_valid, out_task, out_locale, out_slot, out_thread, out_object,
    output out_ready, out_fifo_occ, gvt_valid, gvt_slot,
    output cfg_wvalid, cfg_waddr, cfg_wdata, cfg_arvalid, cfg_araddr,
    input  cfg_rvalid, cfg_rdata
  );
endinterface

// File: rtl/rw_read_stage.sv
// rw_read_stage: read stage of the task pipeline. Read tasks issue an AXI
// read for their object (context parked per thread until the response);
// no_read / restore tasks skip memory and go through a one-entry bypass
// register. Every emitted task's object is recorded in a per-slot undo log,
// which restore tasks read back.
// Ports:
//   clk    : clock
//   rstn   : synchronous active-low reset
//   io_bus : rw_read_stage_if.slave (task in, AR/R, task out, flow control, cfg)
// Config map: 0x00 base, 0x04 thresh (reads out_fifo_occ), 0x08 deq_remaining,
//   0x0C max_out (reads outstanding).
// Optional: define RW_READ_STATS_EN for counters at 0x10 reads issued,
//   0x14 bypass tasks, 0x18 threshold-stall cycles.
module rw_read_stage #(
  parameter int N_THREADS       = 16,
  parameter int CQ_SLOTS        = 64,
  parameter int OBJ_W           = 32,
  parameter int TASK_W          = 96,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic            clk,
  input logic            rstn,
  rw_read_stage_if.slave io_bus
);
  localparam int TID_W  = $clog2(N_THREADS);
  localparam int SLOT_W = $clog2(CQ_SLOTS);
  localparam int LANES  = 512 / OBJ_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] BYTES = 32'(OBJ_W / 8);

  logic [31:0]      r_base, r_deq_rem;
  logic [7:0]       r_thresh;
  logic [CNT_W-1:0] r_max_out, r_outstanding;
  logic             r_cfg_rvalid;
  logic [31:0]      r_cfg_rdata;

  logic              r_byp_valid;
  logic [TASK_W-1:0] r_byp_task;
  logic [31:0]       r_byp_locale;
  logic [SLOT_W-1:0] r_byp_slot;
  logic [TID_W-1:0]  r_byp_thread;
  logic [OBJ_W-1:0]  r_byp_obj;

  logic [TASK_W-1:0] r_ctx_task   [N_THREADS];
  logic [31:0]       r_ctx_locale [N_THREADS];
  logic [SLOT_W-1:0] r_ctx_slot   [N_THREADS];
  logic [OBJ_W-1:0]  r_undo       [CQ_SLOTS];

  logic w_is_byp, w_thr_ok, w_gvt_hit, w_can_deq, w_byp_drain;
  logic w_arvalid, w_in_ready, w_accept, w_rd_accept, w_byp_accept;
  logic w_rready, w_resp, w_out_valid, w_out_fire;
  logic [TASK_W-1:0] w_out_task;
  logic [31:0]       w_out_locale, w_rsp_locale, w_cfg_rd;
  logic [SLOT_W-1:0] w_out_slot;
  logic [TID_W-1:0]  w_out_thread;
  logic [OBJ_W-1:0]  w_out_obj, w_rd_obj, w_undo_rd, w_byp_obj;

  assign w_is_byp    = io_bus.in_no_read | io_bus.in_restore;
  assign w_thr_ok    = io_bus.out_fifo_occ < r_thresh;
  assign w_gvt_hit   = io_bus.gvt_valid && (io_bus.gvt_slot == io_bus.in_slot);
  assign w_can_deq   = (r_deq_rem != '0) && (r_outstanding < r_max_out) &&
                       (w_thr_ok || w_gvt_hit);
  assign w_byp_drain = r_byp_valid && io_bus.out_ready;
  assign w_arvalid   = rstn && io_bus.in_valid && !w_is_byp && w_can_deq;

  always_comb begin
    w_in_ready = 1'b0;
    if (rstn) begin
      if (w_is_byp) w_in_ready = w_can_deq && (!r_byp_valid || w_byp_drain);
      else          w_in_ready = w_arvalid && io_bus.arready;
    end
  end

  assign w_accept     = io_bus.in_valid && w_in_ready;
  assign w_rd_accept  = w_accept && !w_is_byp;
  assign w_byp_accept = w_accept && w_is_byp;

  // Bypass register outranks memory responses; a response waits via rready.
  assign w_rready    = rstn && io_bus.rvalid && io_bus.out_ready && !r_byp_valid;
  assign w_resp      = io_bus.rvalid && w_rready;
  assign w_out_valid = rstn && (r_byp_valid || io_bus.rvalid);
  assign w_out_fire  = w_out_valid && io_bus.out_ready;

  assign w_rsp_locale = r_ctx_locale[io_bus.rid];

  if (LANES == 1) begin : g_full
    assign w_rd_obj = io_bus.rdata;
  end else begin : g_lane
    logic [LANE_W-1:0] w_lane;
    assign w_lane   = w_rsp_locale[LANE_W-1:0];
    assign w_rd_obj = io_bus.rdata[w_lane*OBJ_W +: OBJ_W];
  end

  always_comb begin
    w_out_task   = r_byp_task;
    w_out_locale = r_byp_locale;
    w_out_slot   = r_byp_slot;
    w_out_thread = r_byp_thread;
    w_out_obj    = r_byp_obj;
    if (!r_byp_valid) begin
      w_out_task   = r_ctx_task[io_bus.rid];
      w_out_locale = w_rsp_locale;
      w_out_slot   = r_ctx_slot[io_bus.rid];
      w_out_thread = io_bus.rid;
      w_out_obj    = w_rd_obj;
    end
  end

  // Undo log is write-first: a restore of the slot being written this cycle
  // takes the value going out now.
  assign w_undo_rd = (w_out_fire && (w_out_slot == io_bus.in_slot)) ? w_out_obj
                                                                    : r_undo[io_bus.in_slot];
  assign w_byp_obj = io_bus.in_restore ? w_undo_rd : '0;

`ifdef RW_READ_STATS_EN
  logic [31:0] r_st_reads, r_st_byp, r_st_stall;
`endif

  always_comb begin
    w_cfg_rd = '0;
    case (io_bus.cfg_araddr)
      8'h00: w_cfg_rd = r_base;
      8'h04: w_cfg_rd = {24'h0, io_bus.out_fifo_occ};
      8'h08: w_cfg_rd = r_deq_rem;
      8'h0C: w_cfg_rd = 32'(r_outstanding);
`ifdef RW_READ_STATS_EN
      8'h10: w_cfg_rd = r_st_reads;
      8'h14: w_cfg_rd = r_st_byp;
      8'h18: w_cfg_rd = r_st_stall;
`endif
      default: w_cfg_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_base        <= '0;
      r_thresh      <= '1;
      r_deq_rem     <= '1;
      r_max_out     <= CNT_W'(MAX_OUTSTANDING);
      r_outstanding <= '0;
      r_byp_valid   <= 1'b0;
      r_cfg_rvalid  <= 1'b0;
      r_cfg_rdata   <= '0;
    end else begin
      if (io_bus.cfg_wvalid) begin
        case (io_bus.cfg_waddr)
          8'h00: r_base   <= {io_bus.cfg_wdata[29:0], 2'b00};
          8'h04: r_thresh <= io_bus.cfg_wdata[7:0];
          8'h0C: r_max_out <= (io_bus.cfg_wdata > 32'(MAX_OUTSTANDING))
                              ? CNT_W'(MAX_OUTSTANDING) : io_bus.cfg_wdata[CNT_W-1:0];
          default: ;
        endcase
      end
      if (io_bus.cfg_wvalid && (io_bus.cfg_waddr == 8'h08))
        r_deq_rem <= io_bus.cfg_wdata;
      else if (w_accept && (r_deq_rem != '0))
        r_deq_rem <= r_deq_rem - 32'd1;

      case ({w_rd_accept, w_resp})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: ;
      endcase

      if (w_byp_accept)     r_byp_valid <= 1'b1;
      else if (w_byp_drain) r_byp_valid <= 1'b0;

      r_cfg_rvalid <= io_bus.cfg_arvalid;
      if (io_bus.cfg_arvalid) r_cfg_rdata <= w_cfg_rd;
    end
  end

`ifdef RW_READ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_st_reads <= '0;
      r_st_byp   <= '0;
      r_st_stall <= '0;
    end else begin
      if (w_rd_accept && (r_st_reads != '1)) r_st_reads <= r_st_reads + 32'd1;
      if (w_byp_accept && (r_st_byp != '1))  r_st_byp   <= r_st_byp + 32'd1;
      if (io_bus.in_valid && !(w_thr_ok || w_gvt_hit) && (r_st_stall != '1))
        r_st_stall <= r_st_stall + 32'd1;
    end
  end
`endif

  // Payload storage: not reset, only written by qualified handshakes.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ctx_task[io_bus.in_thread]   <= io_bus.in_task;
      r_ctx_locale[io_bus.in_thread] <= io_bus.in_locale;
      r_ctx_slot[io_bus.in_thread]   <= io_bus.in_slot;
    end
    if (w_byp_accept) begin
      r_byp_task   <= io_bus.in_task;
      r_byp_locale <= io_bus.in_locale;
      r_byp_slot   <= io_bus.in_slot;
      r_byp_thread <= io_bus.in_thread;
      r_byp_obj    <= w_byp_obj;
    end
    if (w_out_fire) r_undo[w_out_slot] <= w_out_obj;
  end

  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.arvalid    = w_arvalid;
  assign io_bus.araddr     = r_base + io_bus.in_locale * BYTES;
  assign io_bus.arid       = io_bus.in_thread;
  assign io_bus.rready     = w_rready;
  assign io_bus.out_valid  = w_out_valid;
  assign io_bus.out_task   = w_out_task;
  assign io_bus.out_locale = w_out_locale;
  assign io_bus.out_slot   = w_out_slot;
  assign io_bus.out_thread = w_out_thread;
  assign io_bus.out_object = w_out_obj;
  assign io_bus.cfg_rvalid = r_cfg_rvalid;
  assign io_bus.cfg_rdata  = r_cfg_rdata;
endmodule
